// File: rtl/bin_to_dec_scan.sv
// Serial double-dabble binary-to-BCD converter with a multiplexed digit scanner.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank most-significant zero digits at commit).
module bin_to_dec_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BIN_W-1:0]  bin,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        digit,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CAT_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10_minus1(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

  localparam longint unsigned MAX_VAL = pow10_minus1(DIGITS);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                  state_q, state_d;
  logic [BIN_W-1:0]        shift_q, shift_d;
  logic [DIGITS-1:0][3:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    oflag_q, oflag_d;
  logic [DIGITS-1:0][3:0]  stored_q, stored_d;
  logic                    busy_d, ovf_d;

  logic [DIGITS-1:0][3:0]  corr;
  logic [CAT_W-1:0]        cat;
  logic [DIGITS-1:0][3:0]  commit_val;

  // One double-dabble step: add-3 correction, then shift {bcd, shift} left.
  always_comb begin
    corr = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[i] >= 4'd5) corr[i] = bcd_q[i] + 4'd3;
    end
    cat = {corr, shift_q} << 1;
    commit_val = cat[CAT_W-1:BIN_W];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        if (lead && commit_val[i] == 4'd0) commit_val[i] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
  end

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    oflag_d  = oflag_q;
    stored_d = stored_q;
    busy_d   = busy;
    ovf_d    = ovf;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          oflag_d = 64'(bin) > MAX_VAL;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        shift_d = cat[BIN_W-1:0];
        bcd_d   = cat[CAT_W-1:BIN_W];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          ovf_d    = oflag_q;
          stored_d = oflag_q ? '1 : commit_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      oflag_q  <= 1'b0;
      stored_q <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      oflag_q  <= oflag_d;
      stored_q <= stored_d;
      busy     <= busy_d;
      ovf      <= ovf_d;
    end
  end

  logic [PRE_W-1:0] pre_q;
  logic [IDX_W-1:0] idx_q;
  logic             tick;
  logic [IDX_W-1:0] idx_next;

  // Scanner: prescaler tick advances the digit index, wrapping at DIGITS-1.
  always_comb begin
    tick     = (pre_q == PRE_W'(SCAN_DIV - 1));
    idx_next = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // Select lines and digit code load together so the bus never shows a mixed slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      an    <= '1;
      digit <= 4'hF;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        idx_q <= idx_next;
        an    <= ~(DIGITS'(1) << idx_next);
        digit <= stored_q[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_bin_to_dec_scan.sv
// Randomized self-checking bench for bin_to_dec_scan (DIGITS=4, BIN_W=14, SCAN_DIV=4).
// Expected displays come from decimal arithmetic on the loaded value.
module tb_bin_to_dec_scan;

  logic        clk;
  logic        rst;
  logic        load;
  logic [13:0] bin;
  logic        busy;
  logic        ovf;
  logic [3:0]  digit;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_dec_scan #(.DIGITS(4), .BIN_W(14), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .bin(bin),
    .busy(busy), .ovf(ovf), .digit(digit), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-slot codes, index 0 in the low nibble.
  function automatic logic [15:0] model_disp(input int v);
    logic [15:0] r;
    int t;
    if (v > 9999) return 16'hFFFF;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  task automatic check_display(input logic [15:0] exp);
    int idx;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx = -1;
      for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) idx = j;
      check_eq("an_onehot", 32'($countones(~an)), 32'd1);
      if (idx >= 0) check_eq($sformatf("digit[%0d]", idx), 32'(digit), 32'(exp[idx*4 +: 4]));
    end
  endtask

  // Load v and count busy cycles; optional ignored load pulses or a mid-conversion reset.
  task automatic run_conv(input int v, input bit pulse, input int rst_at, output int n);
    @(negedge clk);
    load = 1'b1;
    bin  = 14'(v);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq("busy_on_rst", 32'(busy), 32'd0);
        check_eq("an_on_rst", 32'(an), 32'hF);
        return;
      end
      load = pulse && (n == 3 || n == 13);
      bin  = 14'd99;
      @(negedge clk);
      n++;
    end
    load = 1'b0;
  endtask

  task automatic conv_and_check(input int v, input bit pulse);
    int n;
    run_conv(v, pulse, -1, n);
    check_eq($sformatf("busy_cycles(%0d)", v), 32'(n), 32'd14);
    check_eq($sformatf("ovf(%0d)", v), 32'(ovf), 32'(v > 9999));
    if (pulse) begin
      @(negedge clk);
      check_eq("busy_after_ignored_load", 32'(busy), 32'd0);
    end
    check_display(model_disp(v));
  endtask

  initial begin
    int n;
    int v;
    rst  = 1'b1;
    load = 1'b0;
    bin  = '0;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_digit", 32'(digit), 32'hF);
    check_eq("rst_an", 32'(an), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("an_before_tick", 32'(an), 32'hF);
    @(negedge clk);
    check_eq("tick1_an", 32'(an), 32'hD);
    check_eq("tick1_digit", 32'(digit), 32'h0);
    repeat (4) @(negedge clk);
    check_eq("tick2_an", 32'(an), 32'hB);
    repeat (4) @(negedge clk);
    check_eq("tick3_an", 32'(an), 32'h7);
    repeat (4) @(negedge clk);
    check_eq("tick4_an", 32'(an), 32'hE);

    conv_and_check(1234, 1'b0);
    conv_and_check(10000, 1'b0);
    conv_and_check(9999, 1'b0);
    conv_and_check(42, 1'b1);
    conv_and_check(0, 1'b0);
    conv_and_check(1002, 1'b0);
    conv_and_check(16383, 1'b0);
    for (int r = 0; r < 6; r++) begin
      v = (r % 3 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      conv_and_check(v, 1'b0);
    end

    conv_and_check(1234, 1'b0);
    run_conv(5678, 1'b0, 7, n);
    @(negedge clk);
    rst = 1'b0;
    check_eq("ovf_after_abort", 32'(ovf), 32'd0);
    check_eq("busy_after_abort", 32'(busy), 32'd0);
    check_display(16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
